// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues one imem request per PC, buffers the result
// in the IF/ID register, and tells the PC register when to advance.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            id_valid,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_fault,
  input  logic            id_ready
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] req_pc;
  logic            free;
  logic            aligned;
  logic            req_go;
  logic            rsp_cap;
  logic            mis_cap;
  logic            capture;

  assign free          = !id_valid || id_ready;
  assign aligned       = (pc[1:0] == 2'b00);
  assign imem_req_addr = pc;

  // Next-state and handshake outputs; request/enable are forced low in reset.
  always_comb begin
    state_nxt = state;
    req_go    = 1'b0;
    rsp_cap   = 1'b0;
    mis_cap   = 1'b0;
    case (state)
      REQ: begin
        req_go  = free && !flush && aligned;
        mis_cap = free && !flush && !aligned;
        if (req_go && imem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          rsp_cap   = !flush;
          state_nxt = REQ;
        end else if (flush) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
    capture        = rsp_cap || mis_cap;
    imem_req_valid = reset && req_go;
    pc_en          = reset && (flush || capture);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= REQ;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (req_go && imem_req_ready) req_pc <= pc;
    end
  end

  // IF/ID register: flush beats capture, capture beats consumption.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_fault <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (rsp_cap) begin
      id_valid <= 1'b1;
      id_instr <= imem_rsp_data;
      id_pc    <= req_pc;
      id_fault <= imem_rsp_err;
    end else if (mis_cap) begin
      id_valid <= 1'b1;
      id_instr <= NOP_INSTR;
      id_pc    <= pc;
      id_fault <= 1'b1;
    end else if (id_valid && id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized closed-loop bench for fetch_stage: PC register and imem are
// modelled here; captured instructions are scoreboarded against decode pops.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int NCYC = 4000;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;
  logic        id_ready;

  fetch_stage #(.XLEN(32), .ILEN(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_en(pc_en), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_fault(id_fault), .id_ready(id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        fault;
  } item_t;

  item_t sb[$];
  int    nvec  = 0;
  int    nfail = 0;
  bit    run   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Decode side: every handshake pops the oldest expected instruction.
  always @(negedge clk) begin
    item_t it;
    #2;
    if (run && reset) begin
      chk("id_valid", id_valid, sb.size() != 0);
      if (id_valid && id_ready && sb.size() != 0) begin
        it = sb.pop_front();
        chk("id_pc", id_pc, it.ipc);
        chk("id_instr", id_instr, it.instr);
        chk("id_fault", id_fault, it.fault);
      end
    end
  end

  // Environment state: PC register plus a single-outstanding memory.
  logic [31:0] pc_reg;
  logic [31:0] oaddr;
  bit          out, killed, rsp_fire, free_m, exp_req, exp_mis, exp_cap, took_en, did_rst;
  int          cnt;
  logic [31:0] target;

  initial begin
    reset = 1'b0; pc = 32'h0; flush = 1'b0; id_ready = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    pc_reg = 32'h0; out = 0; killed = 0; cnt = 0; oaddr = '0; did_rst = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst id_valid", id_valid, 1'b0);
    chk("rst id_instr", id_instr, NOP);
    chk("rst id_pc", id_pc, 32'h0);
    chk("rst id_fault", id_fault, 1'b0);
    chk("rst req_valid", imem_req_valid, 1'b0);
    chk("rst pc_en", pc_en, 1'b0);
    run = 1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      reset = 1'b1;
      pc = pc_reg;
      flush = ($urandom_range(0, 11) == 0);
      id_ready = ($urandom_range(0, 9) < 6);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      rsp_fire = 0;
      if (out) begin
        cnt--;
        if (cnt == 0) rsp_fire = 1;
      end
      imem_rsp_valid = rsp_fire;
      imem_rsp_data = $urandom;
      imem_rsp_err = ($urandom_range(0, 7) == 0);
      target = {22'($urandom_range(0, 1023)), 2'b00, 8'h00} >> 8;
      if ($urandom_range(0, 3) == 0) target[1:0] = 2'($urandom_range(1, 3));

      free_m  = (sb.size() == 0) || id_ready;
      exp_req = !out && free_m && !flush && (pc[1:0] == 2'b00);
      exp_mis = !out && free_m && !flush && (pc[1:0] != 2'b00);
      exp_cap = rsp_fire && !killed && !flush;

      #1;
      chk("imem_req_valid", imem_req_valid, exp_req);
      if (exp_req) chk("imem_req_addr", imem_req_addr, pc);
      chk("pc_en", pc_en, flush || exp_cap || exp_mis);
      took_en = pc_en;

      @(posedge clk);
      if (flush) sb.delete();
      if (out && flush) killed = 1;
      if (rsp_fire) out = 0;
      if (exp_cap) sb.push_back('{oaddr, imem_rsp_data, imem_rsp_err});
      if (exp_mis) sb.push_back('{pc, NOP, 1'b1});
      if (exp_req && imem_req_ready) begin
        out = 1; killed = 0; cnt = $urandom_range(1, 3); oaddr = pc;
      end
      if (took_en) pc_reg = flush ? target : pc_reg + 32'd4;

      // Asynchronous reset while a fetch is outstanding.
      if (!did_rst && cyc > 800 && out) begin
        did_rst = 1;
        #3;
        reset = 1'b0;
        #1;
        chk("arst id_valid", id_valid, 1'b0);
        chk("arst id_instr", id_instr, NOP);
        chk("arst id_pc", id_pc, 32'h0);
        chk("arst id_fault", id_fault, 1'b0);
        chk("arst req_valid", imem_req_valid, 1'b0);
        chk("arst pc_en", pc_en, 1'b0);
        sb.delete();
        out = 0; killed = 0; cnt = 0;
      end
    end

    if (!did_rst) chk("mid-run reset reached", 1'b0, 1'b1);
    @(negedge clk);
    run = 0;
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
